// File: rtl/mem_bus_decoder.sv
// Memory-map decoder and slave-select sequencer: region decode, per-region wait states and size limits, registered read data.
// Latency: valid access WAIT+2 cycles to m_ready, unmapped access 1 cycle; one access in flight, master holds request until m_ready.
// Optional macro BUS_ERR_LATCH_EN latches the first unmapped address into err_addr until err_clr.
module mem_bus_decoder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RSEL_W = 2,
  parameter logic [4*(2**RSEL_W)-1:0] WAIT_STATES = '0,
  parameter logic [8*(2**RSEL_W)-1:0] SIZE_BITS = {8'd8, 8'd13, 8'd14, 8'd14}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_W-1:0]                m_addr,
  input  logic [DATA_W-1:0]                m_wdata,
  input  logic                             m_read,
  input  logic                             m_write,
  output logic [DATA_W-1:0]                m_rdata,
  output logic                             m_ready,
  output logic                             m_err,
  output logic [(2**RSEL_W)-1:0]           s_cs,
  output logic                             s_write,
  output logic [ADDR_W-RSEL_W-1:0]         s_addr,
  output logic [DATA_W-1:0]                s_wdata,
  input  logic [(2**RSEL_W)*DATA_W-1:0]    s_rdata,
  input  logic                             err_clr,
  output logic [ADDR_W-1:0]                err_addr
);

  localparam int OFF_W = ADDR_W - RSEL_W;
  localparam int NREG  = 2**RSEL_W;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic [RSEL_W-1:0]   region, sel_q, sel_nxt;
  logic [OFF_W-1:0]    offset;
  logic [7:0]          size_sel;
  logic [3:0]          wait_sel, cnt, cnt_nxt;
  logic                req, addr_vld;
  logic [NREG-1:0]     cs_nxt;
  logic                write_nxt, ready_nxt, err_nxt;
  logic [OFF_W-1:0]    saddr_nxt;
  logic [DATA_W-1:0]   wdata_nxt, rdata_nxt;

  assign region   = m_addr[ADDR_W-1 -: RSEL_W];
  assign offset   = m_addr[OFF_W-1:0];
  assign size_sel = SIZE_BITS[8*region +: 8];
  assign wait_sel = WAIT_STATES[4*region +: 4];
  assign req      = m_read | m_write;
  // A shift by the full offset width yields zero, so a full-size region is always valid.
  assign addr_vld = ((offset >> size_sel) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cs_nxt    = s_cs;
    write_nxt = s_write;
    saddr_nxt = s_addr;
    wdata_nxt = s_wdata;
    rdata_nxt = m_rdata;
    sel_nxt   = sel_q;
    cnt_nxt   = cnt;
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (addr_vld) begin
            cs_nxt         = '0;
            cs_nxt[region] = 1'b1;
            write_nxt      = m_write;
            saddr_nxt      = offset;
            wdata_nxt      = m_wdata;
            sel_nxt        = region;
            cnt_nxt        = wait_sel;
            state_nxt      = ACCESS;
          end else begin
            rdata_nxt = '0;
            ready_nxt = 1'b1;
            err_nxt   = 1'b1;
            state_nxt = RESP;
          end
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          if (!s_write) rdata_nxt = s_rdata[DATA_W*sel_q +: DATA_W];
          cs_nxt    = '0;
          write_nxt = 1'b0;
          ready_nxt = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cs    <= '0;
      s_write <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_rdata <= '0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      sel_q   <= '0;
      cnt     <= '0;
    end else begin
      s_cs    <= cs_nxt;
      s_write <= write_nxt;
      s_addr  <= saddr_nxt;
      s_wdata <= wdata_nxt;
      m_rdata <= rdata_nxt;
      m_ready <= ready_nxt;
      m_err   <= err_nxt;
      sel_q   <= sel_nxt;
      cnt     <= cnt_nxt;
    end
  end

`ifdef BUS_ERR_LATCH_EN
  logic              err_latched;
  logic [ADDR_W-1:0] err_addr_q;
  logic              err_evt;

  assign err_evt = (state == IDLE) && req && !addr_vld;

  // Clear wins over an error sampled in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_latched <= 1'b0;
      err_addr_q  <= '0;
    end else if (err_clr) begin
      err_latched <= 1'b0;
      err_addr_q  <= '0;
    end else if (err_evt && !err_latched) begin
      err_latched <= 1'b1;
      err_addr_q  <= m_addr;
    end
  end

  assign err_addr = err_addr_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_addr       = '0;
`endif

endmodule
